alien_march_ctrl: RTL and testbench
===================================

ALIEN_MARCH_CTRL -- requirements
Module: alien_march_ctrl

Interface
REQ-001 Parameter X_WIDTH, 10, width of the formation x offset.
REQ-002 Parameter Y_WIDTH, 9, width of the formation y offset.
REQ-003 Parameters COL_PITCH=16, ALIEN_W=12: column spacing and sprite width, in pixels.
REQ-004 Parameters X_MIN=8, X_MAX=631: inclusive horizontal playfield bounds.
REQ-005 Parameters X_START=100, Y_START=64: formation origin after restart.
REQ-006 Parameters STEP_X=2, STEP_Y=8, Y_LIMIT=400: march step, drop step, landing row.
REQ-007 Parameters MIN_PERIOD=1, PERIOD_SHIFT=2: step-period base and alive-count scaling.
REQ-008 clk  input  1  system clock, all state on rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 enable  input  1  game running; 0 pauses the march.
REQ-012 restart  input  1  synchronous pulse that re-initialises the formation.
REQ-013 alive_count  input  6  number of living aliens, 0..55.
REQ-014 left_col, right_col  input  4 each  leftmost and rightmost alive column, 0..10.
REQ-015 x_off  output  X_WIDTH  formation x origin; y_off  output  Y_WIDTH  formation y origin.
REQ-016 dir  output  1  1 = marching right; anim_frame  output  1  sprite frame select.
REQ-017 step_pulse  output  1  one-cycle pulse on every formation move; landed  output  1  formation reached Y_LIMIT.

Function
REQ-018 States IDLE, WAIT, STEP, LANDED, with a frame counter cnt of 5 bits.
REQ-019 period = MIN_PERIOD + (alive_count >> PERIOD_SHIFT); with 55 alive, period = 14 frames.
REQ-020 IDLE: all outputs hold; enable=1 moves to WAIT on the next clock.
REQ-021 WAIT, enable=0: return to IDLE with cnt cleared.
REQ-022 WAIT, frame_tick with alive_count=0: ignored; cnt holds at 0 and no step occurs.
REQ-023 WAIT, frame_tick with cnt==period-1: cnt clears and the FSM enters STEP.
REQ-024 WAIT, any other frame_tick: cnt increments.
REQ-025 Edge pixels are computed in X_WIDTH+4 bits, with no wrap:
  - L = x_off + left_col*COL_PITCH
  - R = x_off + right_col*COL_PITCH + ALIEN_W - 1
REQ-026 STEP lasts one cycle and asserts step_pulse; anim_frame toggles.
REQ-027 STEP, edge hit: hit = (dir=1 and R+STEP_X > X_MAX) or (dir=0 and L < X_MIN+STEP_X). On a hit, y_off += STEP_Y, dir inverts, and x_off is unchanged.
REQ-028 STEP, no hit: x_off moves by ±STEP_X according to dir.
REQ-029 STEP exit: go to LANDED if the new y_off >= Y_LIMIT; otherwise go to WAIT.
REQ-030 LANDED: landed=1; frame_tick and enable are ignored until restart.
REQ-031 restart has priority over every other event, including a coincident frame_tick or STEP. It sets x_off=X_START, y_off=Y_START, dir=1, anim_frame=0, cnt=0, landed=0, step_pulse=0 and state IDLE.
REQ-032 Latency: step_pulse and the new x_off/y_off appear one clock after the terminal frame_tick is sampled.

Reset
REQ-033 rst_n=0 immediately forces the restart values of REQ-031, independent of clk.
REQ-034 Reset asserted mid-WAIT or mid-STEP discards the pending step; no step_pulse follows reset release.

Structure
REQ-035 The state enum typedef and default geometry constants SHALL live in shared package invaders_pkg.
REQ-036 The frame-period counter with dynamic terminal count SHALL be sub-module march_timer, with inputs tick, period and clear and output done.

Verification
REQ-037 Scenario 1: reset, enable=1, alive=55, cols 0..10, 14 frame_ticks -> exactly one step_pulse and x_off 100->102.
REQ-038 Scenario 2: march right 180 steps -> x_off=460 (R=631); next step -> y_off 64->72, dir=0, x_off stays 460.
REQ-039 Scenario 3: alive_count=0, 100 frame_ticks -> no step_pulse, all outputs constant.
REQ-040 Scenario 4: force repeated drops until y_off>=400 -> landed=1; further ticks give no pulses; restart -> landed=0, x_off=100, y_off=64.
REQ-041 Scenario 5: restart coincident with the terminal frame_tick -> no step_pulse, restart values, state IDLE.
REQ-042 Scenario 6: rst_n pulse asserted between clock edges during WAIT -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/invaders_pkg.sv
// Shared definitions for the alien formation march logic.
//   - march_state_e : formation controller state encoding
//   - DEF_*         : default playfield geometry and timing constants
//   - step_period() : frames between formation moves for a given alive count
package invaders_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STEP   = 2'd2,
    ST_LANDED = 2'd3
  } march_state_e;

  localparam int DEF_X_WIDTH      = 10;
  localparam int DEF_Y_WIDTH      = 9;
  localparam int DEF_COL_PITCH    = 16;
  localparam int DEF_ALIEN_W      = 12;
  localparam int DEF_X_MIN        = 8;
  localparam int DEF_X_MAX        = 631;
  localparam int DEF_X_START      = 100;
  localparam int DEF_Y_START      = 64;
  localparam int DEF_STEP_X       = 2;
  localparam int DEF_STEP_Y       = 8;
  localparam int DEF_Y_LIMIT      = 400;
  localparam int DEF_MIN_PERIOD   = 1;
  localparam int DEF_PERIOD_SHIFT = 2;

  // Frame counter width: 63 >> 2 = 15, plus a base of 1, still fits in 5 bits.
  localparam int CNT_W = 5;

  // Fewer aliens -> shorter period -> faster march.
  function automatic logic [CNT_W-1:0] step_period(input logic [5:0] alive,
                                                   input int        min_period,
                                                   input int        shift);
    step_period = CNT_W'(min_period) + CNT_W'(alive >> shift);
  endfunction

endpackage

// File: rtl/march_timer.sv
// Frame-period counter with a run-time terminal count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : count one frame (qualified by the caller)
//   period     : number of ticks per done pulse (must be >= 1)
//   clear      : synchronous clear, wins over tick
//   done       : combinational strobe, high on the terminal tick
module march_timer
  import invaders_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [CW-1:0] period,
  input  logic          clear,
  output logic          done
);

  logic [CW-1:0] cnt_r;

  // Terminal tick: the one that completes the current period.
  always_comb begin
    done = tick & (cnt_r == (period - CW'(1)));
  end

  // Frame counter: clear, wrap on terminal tick, otherwise count ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (done) begin
      cnt_r <= '0;
    end else if (tick) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march controller.
// Counts video frames and moves the formation one step every period frames,
// where the period shrinks as aliens die. On reaching a playfield edge the
// formation drops a row and reverses; at the landing row it stops for good
// until restarted.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   frame_tick            : one pulse per video frame
//   enable                : 0 pauses the march
//   restart               : synchronous re-initialisation (highest priority)
//   alive_count           : living aliens, 0..55 (0 freezes the march)
//   left_col, right_col   : outermost living columns, 0..10
//   x_off, y_off          : formation origin in pixels
//   dir                   : 1 = marching right
//   anim_frame            : sprite frame, toggles on every move
//   step_pulse            : one-cycle pulse on every move
//   landed                : formation reached the landing row
module alien_march_ctrl
  import invaders_pkg::*;
#(
  parameter int X_WIDTH      = DEF_X_WIDTH,
  parameter int Y_WIDTH      = DEF_Y_WIDTH,
  parameter int COL_PITCH    = DEF_COL_PITCH,
  parameter int ALIEN_W      = DEF_ALIEN_W,
  parameter int X_MIN        = DEF_X_MIN,
  parameter int X_MAX        = DEF_X_MAX,
  parameter int X_START      = DEF_X_START,
  parameter int Y_START      = DEF_Y_START,
  parameter int STEP_X       = DEF_STEP_X,
  parameter int STEP_Y       = DEF_STEP_Y,
  parameter int Y_LIMIT      = DEF_Y_LIMIT,
  parameter int MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int PERIOD_SHIFT = DEF_PERIOD_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               restart,
  input  logic [5:0]         alive_count,
  input  logic [3:0]         left_col,
  input  logic [3:0]         right_col,
  output logic [X_WIDTH-1:0] x_off,
  output logic [Y_WIDTH-1:0] y_off,
  output logic               dir,
  output logic               anim_frame,
  output logic               step_pulse,
  output logic               landed
);

  // Edge arithmetic is widened so the column offset can never wrap.
  localparam int EW = X_WIDTH + 4;

  march_state_e       state_r;
  march_state_e       state_nxt_s;
  logic [X_WIDTH-1:0] x_nxt_s;
  logic [Y_WIDTH-1:0] y_nxt_s;
  logic               dir_nxt_s;
  logic               anim_nxt_s;
  logic               pulse_nxt_s;
  logic               landed_nxt_s;

  logic [CNT_W-1:0]   period_s;
  logic               timer_tick_s;
  logic               timer_clear_s;
  logic               timer_done_s;
  logic [EW-1:0]      edge_l_s;
  logic [EW-1:0]      edge_r_s;
  logic               edge_hit_s;

  // Timer qualification lives outside the FSM process so its done strobe
  // feeds next-state logic without a combinational loop. A dead formation
  // (alive_count == 0) never ticks, so the counter simply holds.
  always_comb begin
    period_s      = step_period(alive_count, MIN_PERIOD, PERIOD_SHIFT);
    timer_tick_s  = (state_r == ST_WAIT) & enable & frame_tick & (alive_count != 6'd0);
    timer_clear_s = restart | ~((state_r == ST_WAIT) & enable);
  end

  march_timer #(
    .CW (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (timer_tick_s),
    .period (period_s),
    .clear  (timer_clear_s),
    .done   (timer_done_s)
  );

  // Outer pixel edges of the living formation and the edge-hit decision.
  always_comb begin
    edge_l_s   = EW'(x_off) + EW'(left_col) * EW'(COL_PITCH);
    edge_r_s   = EW'(x_off) + EW'(right_col) * EW'(COL_PITCH) + EW'(ALIEN_W - 1);
    if (dir) begin
      edge_hit_s = (edge_r_s + EW'(STEP_X)) > EW'(X_MAX);
    end else begin
      edge_hit_s = edge_l_s < EW'(X_MIN + STEP_X);
    end
  end

  // Next-state and next-output logic. The move is computed on the terminal
  // tick so the new position and step_pulse are visible during STEP.
  always_comb begin
    state_nxt_s  = state_r;
    x_nxt_s      = x_off;
    y_nxt_s      = y_off;
    dir_nxt_s    = dir;
    anim_nxt_s   = anim_frame;
    pulse_nxt_s  = 1'b0;
    landed_nxt_s = landed;
    if (restart) begin
      state_nxt_s  = ST_IDLE;
      x_nxt_s      = X_WIDTH'(X_START);
      y_nxt_s      = Y_WIDTH'(Y_START);
      dir_nxt_s    = 1'b1;
      anim_nxt_s   = 1'b0;
      landed_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!enable) begin
            state_nxt_s = ST_IDLE;
          end else if (timer_done_s) begin
            state_nxt_s = ST_STEP;
            pulse_nxt_s = 1'b1;
            anim_nxt_s  = ~anim_frame;
            if (edge_hit_s) begin
              y_nxt_s   = y_off + Y_WIDTH'(STEP_Y);
              dir_nxt_s = ~dir;
            end else if (dir) begin
              x_nxt_s = x_off + X_WIDTH'(STEP_X);
            end else begin
              x_nxt_s = x_off - X_WIDTH'(STEP_X);
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_STEP: begin
          if (y_off >= Y_WIDTH'(Y_LIMIT)) begin
            state_nxt_s  = ST_LANDED;
            landed_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_LANDED: begin
          state_nxt_s  = ST_LANDED;
          landed_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset loads the restart position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      x_off      <= X_WIDTH'(X_START);
      y_off      <= Y_WIDTH'(Y_START);
      dir        <= 1'b1;
      anim_frame <= 1'b0;
      step_pulse <= 1'b0;
      landed     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      x_off      <= x_nxt_s;
      y_off      <= y_nxt_s;
      dir        <= dir_nxt_s;
      anim_frame <= anim_nxt_s;
      step_pulse <= pulse_nxt_s;
      landed     <= landed_nxt_s;
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Self-checking bench for alien_march_ctrl.
// A frame-counting reference model (number of frames seen vs. period,
// pixel edges in plain integers) predicts every output after each clock.
module tb_alien_march_ctrl;

  localparam int X_START = 100;
  localparam int Y_START = 64;
  localparam int Y_LIMIT = 400;
  localparam logic [23:0] RESTART_VEC = {10'd100, 9'd64, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       restart = 1'b0;
  logic [5:0] alive_count = 6'd0;
  logic [3:0] left_col = 4'd0;
  logic [3:0] right_col = 4'd10;
  logic [9:0] x_off;
  logic [8:0] y_off;
  logic       dir;
  logic       anim_frame;
  logic       step_pulse;
  logic       landed;
  logic [23:0] obs_vec;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position, direction, sprite frame, and progress flags.
  int m_x, m_y, m_frames;
  bit m_dir, m_anim, m_pulse, m_landed, m_active;

  alien_march_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .restart     (restart),
    .alive_count (alive_count),
    .left_col    (left_col),
    .right_col   (right_col),
    .x_off       (x_off),
    .y_off       (y_off),
    .dir         (dir),
    .anim_frame  (anim_frame),
    .step_pulse  (step_pulse),
    .landed      (landed)
  );

  assign obs_vec = {x_off, y_off, dir, anim_frame, step_pulse, landed};

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_x = X_START; m_y = Y_START; m_dir = 1'b1; m_anim = 1'b0;
    m_pulse = 1'b0; m_landed = 1'b0; m_active = 1'b0; m_frames = 0;
  endfunction

  function automatic logic [23:0] model_vec();
    return {10'(m_x), 9'(m_y), m_dir, m_anim, m_pulse, m_landed};
  endfunction

  // One clock of game rules applied to the inputs present at the edge.
  function automatic void model_clock();
    int l_px, r_px;
    bit hit;
    if (!rst_n || restart) begin
      model_reset();
    end else if (m_landed) begin
      m_pulse = 1'b0;
    end else if (m_pulse) begin
      m_pulse = 1'b0;
      if (m_y >= Y_LIMIT) m_landed = 1'b1;
      else m_active = 1'b1;
    end else if (!m_active) begin
      if (enable) m_active = 1'b1;
    end else if (!enable) begin
      m_active = 1'b0;
      m_frames = 0;
    end else if (frame_tick && alive_count != 0) begin
      m_frames++;
      if (m_frames == 1 + int'(alive_count) / 4) begin
        m_frames = 0;
        m_active = 1'b0;
        m_pulse  = 1'b1;
        m_anim   = ~m_anim;
        l_px = m_x + int'(left_col) * 16;
        r_px = m_x + int'(right_col) * 16 + 11;
        hit  = m_dir ? (r_px + 2 > 631) : (l_px < 10);
        if (hit) begin
          m_y   = m_y + 8;
          m_dir = ~m_dir;
        end else if (m_dir) begin
          m_x = (m_x + 2) % 1024;
        end else begin
          m_x = (m_x + 1024 - 2) % 1024;
        end
      end
    end
  endfunction

  task automatic tick_clock();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1; enable = 1'b0; frame_tick = 1'b0;
    tick_clock();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (obs_vec !== RESTART_VEC) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", obs_vec, RESTART_VEC);
    end
    rst_n = 1'b1;
    tick_clock();
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %h expected %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_first_step();
    int pulses = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd55; left_col = 4'd0; right_col = 4'd10;
    tick_clock();
    for (int i = 0; i < 14; i++) begin
      frame_tick = 1'b1;
      tick_clock();
      frame_tick = 1'b0;
      pulses += int'(step_pulse);
      n_checks++;
      if (step_pulse !== ((i == 13) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL first_step_latency: frame %0d pulse got %b", i + 1, step_pulse);
      end
      tick_clock();
      pulses += int'(step_pulse);
    end
    n_checks++;
    if (pulses !== 1 || x_off !== 10'd102) begin
      n_fail++;
      $display("FAIL first_step_result: pulses %0d x_off %0d expected 1 and 102", pulses, x_off);
    end
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL first_step_model: got %h expected %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_march_edge();
    int pulses = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd3; frame_tick = 1'b1;
    for (int c = 0; c < 1000 && pulses < 180; c++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    n_checks++;
    if (pulses !== 180 || x_off !== 10'd460 || y_off !== 9'd64 || dir !== 1'b1) begin
      n_fail++;
      $display("FAIL march_right_edge: pulses %0d x %0d y %0d dir %b expected 180 460 64 1",
               pulses, x_off, y_off, dir);
    end
    for (int c = 0; c < 10 && pulses < 181; c++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    n_checks++;
    if (x_off !== 10'd460 || y_off !== 9'd72 || dir !== 1'b0) begin
      n_fail++;
      $display("FAIL march_drop: x %0d y %0d dir %b expected 460 72 0", x_off, y_off, dir);
    end
    n_checks++;
    if (obs_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL march_model: got %h expected %h", obs_vec, model_vec());
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_no_alive();
    int pulses = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd0;
    tick_clock();
    for (int i = 0; i < 100; i++) begin
      frame_tick = 1'b1;
      tick_clock();
      pulses += int'(step_pulse);
    end
    frame_tick = 1'b0;
    n_checks++;
    if (pulses !== 0 || obs_vec !== RESTART_VEC) begin
      n_fail++;
      $display("FAIL no_alive_frozen: pulses %0d state %h expected 0 and %h", pulses, obs_vec, RESTART_VEC);
    end
  endtask

  task automatic test_landing();
    int pulses = 0;
    int mism = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd2; frame_tick = 1'b1; left_col = 4'd0; right_col = 4'd10;
    for (int c = 0; c < 25000 && landed !== 1'b1; c++) begin
      tick_clock();
      if (obs_vec !== model_vec()) mism++;
    end
    n_checks++;
    if (landed !== 1'b1 || y_off !== 9'd400 || mism != 0) begin
      n_fail++;
      $display("FAIL landing: landed %b y %0d model mismatches %0d expected 1 400 0", landed, y_off, mism);
    end
    for (int i = 0; i < 40; i++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    n_checks++;
    if (pulses !== 0 || landed !== 1'b1) begin
      n_fail++;
      $display("FAIL landed_hold: pulses %0d landed %b expected 0 1", pulses, landed);
    end
    restart = 1'b1;
    tick_clock();
    restart = 1'b0;
    frame_tick = 1'b0; enable = 1'b0;
    n_checks++;
    if (obs_vec !== RESTART_VEC) begin
      n_fail++;
      $display("FAIL landed_restart: got %h expected %h", obs_vec, RESTART_VEC);
    end
  endtask

  task automatic test_restart_coincident();
    int pulses = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd7; frame_tick = 1'b1;
    for (int c = 0; c < 30 && pulses < 2; c++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    frame_tick = 1'b0;
    tick_clock();
    frame_tick = 1'b1;
    tick_clock();
    restart = 1'b1;
    tick_clock();
    restart = 1'b0;
    n_checks++;
    if (obs_vec !== RESTART_VEC) begin
      n_fail++;
      $display("FAIL restart_coincident: got %h expected %h", obs_vec, RESTART_VEC);
    end
    alive_count = 6'd3;
    tick_clock();
    n_checks++;
    if (step_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_to_idle: pulse got %b expected 0", step_pulse);
    end
    tick_clock();
    frame_tick = 1'b0;
    n_checks++;
    if (obs_vec !== model_vec() || x_off !== 10'd102) begin
      n_fail++;
      $display("FAIL restart_resume: got %h expected %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    do_restart();
    enable = 1'b1; alive_count = 6'd7; frame_tick = 1'b1;
    for (int c = 0; c < 30 && pulses < 1; c++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    frame_tick = 1'b0;
    tick_clock();
    frame_tick = 1'b1;
    tick_clock();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec !== RESTART_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", obs_vec, RESTART_VEC);
    end
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      tick_clock();
      pulses += int'(step_pulse);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL reset_discards_step: pulses %0d expected 0", pulses);
    end
    tick_clock();
    frame_tick = 1'b0;
    n_checks++;
    if (obs_vec !== model_vec() || step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_resume: got %h expected %h", obs_vec, model_vec());
    end
  endtask

  task automatic test_random();
    do_restart();
    for (int i = 0; i < 3000; i++) begin
      restart    = ($urandom_range(0, 199) == 0);
      enable     = ($urandom_range(0, 15) != 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      if (m_frames == 0 && $urandom_range(0, 9) == 0) alive_count = 6'($urandom_range(0, 55));
      if ($urandom_range(0, 19) == 0) begin
        left_col  = 4'($urandom_range(0, 10));
        right_col = 4'($urandom_range(int'(left_col), 10));
      end
      tick_clock();
      n_checks++;
      if (obs_vec !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %h expected %h", i, obs_vec, model_vec());
      end
    end
    restart = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_step();
    test_march_edge();
    test_no_alive();
    test_restart_coincident();
    test_async_reset();
    test_landing();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
